// File: rtl/cam_capture.sv
// cam_capture: captures one frame from a DVP-style 8-bit camera into a pixel FIFO.
//
// The camera signals (pclk, vsync, href, din) are treated as plain data and pass
// through the same two-register synchronizer so they stay aligned with each other.
// A sample event is a synchronized pclk 0->1 transition (clk must be >= 4x pclk).
// Two consecutive bytes on a line form one 16-bit pixel {first, second}.
//
// Parameters:
//   FIFO_AW       pixel FIFO address width, depth 2**FIFO_AW words
// Ports:
//   clk, rst      system clock, synchronous active-high reset
//   pclk, vsync, href, din   camera inputs (asynchronous to clk)
//   take_picture  one-cycle start pulse, honoured in IDLE or DONE
//   rd_en         pop one FIFO word; rd_data valid the cycle after
//   rd_data       popped pixel
//   empty         FIFO holds no words
//   busy          capture armed or in progress
//   done          frame complete, held until the next take_picture
//   overflow      sticky, a pixel was dropped because the FIFO was full
//   pix_count     pixels written this frame, saturating
//
// Build option:
//   CAM_CAPTURE_DECIM_EN  2:1 decimation in both directions (keep even lines,
//                         even pixels); when undefined every pixel is kept.
//
// Read/write handshake: a word is written when a pixel is formed and either the
// FIFO is not full or a pop happens in the same cycle; a pop is accepted when the
// FIFO is not empty or a write happens in the same cycle (the written word is
// then forwarded straight to rd_data).
module cam_capture #(
    parameter int FIFO_AW = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pclk,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  din,
    input  logic        take_picture,
    input  logic        rd_en,
    output logic [15:0] rd_data,
    output logic        empty,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic [16:0] pix_count
);

    localparam int DEPTH = 1 << FIFO_AW;

    typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;

    state_t state, state_next;

    // Synchronizer pipeline, stage 1 and 2, plus the previous stage-2 value
    // for edge detection.
    logic       pclk_s1, vsync_s1, href_s1;
    logic [7:0] din_s1;
    logic       pclk_s2, vsync_s2, href_s2;
    logic [7:0] din_s2;
    logic       pclk_d, vsync_d, href_d;

    logic       sample, vsync_fall, vsync_rise, href_fall;
    logic       start, cap_entry;

    logic       phase;
    logic [7:0] hi_byte;

    logic [FIFO_AW:0] wr_ptr, rd_ptr;
    logic [15:0]      mem [DEPTH];
    logic             full;
    logic             pix_formed, pix_keep, wr_ok, rd_ok, drop;
    logic [15:0]      wr_word;

`ifdef CAM_CAPTURE_DECIM_EN
    logic line_par, pix_par;
`endif

    // ------------------------------------------------------------------
    // Synchronizer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_s1  <= 1'b0;
            vsync_s1 <= 1'b0;
            href_s1  <= 1'b0;
            din_s1   <= 8'd0;
            pclk_s2  <= 1'b0;
            vsync_s2 <= 1'b0;
            href_s2  <= 1'b0;
            din_s2   <= 8'd0;
            pclk_d   <= 1'b0;
            vsync_d  <= 1'b0;
            href_d   <= 1'b0;
        end else begin
            pclk_s1  <= pclk;
            vsync_s1 <= vsync;
            href_s1  <= href;
            din_s1   <= din;
            pclk_s2  <= pclk_s1;
            vsync_s2 <= vsync_s1;
            href_s2  <= href_s1;
            din_s2   <= din_s1;
            pclk_d   <= pclk_s2;
            vsync_d  <= vsync_s2;
            href_d   <= href_s2;
        end
    end

    assign sample     = pclk_s2 & ~pclk_d;
    assign vsync_fall = ~vsync_s2 & vsync_d;
    assign vsync_rise = vsync_s2 & ~vsync_d;
    assign href_fall  = ~href_s2 & href_d;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        cap_entry  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (take_picture) begin
                    state_next = ARM;
                    start      = 1'b1;
                end
            end
            ARM: begin
                if (vsync_fall) begin
                    state_next = CAPTURE;
                    cap_entry  = 1'b1;
                end
            end
            CAPTURE: begin
                if (vsync_rise) state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == ARM) || (state == CAPTURE);
    assign done = (state == DONE);

    // ------------------------------------------------------------------
    // Byte pairing and optional decimation parity
    // ------------------------------------------------------------------
    assign pix_formed = (state == CAPTURE) && sample && href_s2 && phase;
    assign wr_word    = {hi_byte, din_s2};

`ifdef CAM_CAPTURE_DECIM_EN
    assign pix_keep = pix_formed && !line_par && !pix_par;
`else
    assign pix_keep = pix_formed;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= 1'b0;
            hi_byte <= 8'd0;
`ifdef CAM_CAPTURE_DECIM_EN
            line_par <= 1'b0;
            pix_par  <= 1'b0;
`endif
        end else if (cap_entry) begin
            phase <= 1'b0;
`ifdef CAM_CAPTURE_DECIM_EN
            line_par <= 1'b0;
            pix_par  <= 1'b0;
`endif
        end else if (href_fall) begin
            // End of line: an unpaired trailing byte is simply forgotten.
            phase <= 1'b0;
`ifdef CAM_CAPTURE_DECIM_EN
            if (state == CAPTURE) line_par <= ~line_par;
            pix_par <= 1'b0;
`endif
        end else if ((state == CAPTURE) && sample && href_s2) begin
            phase <= ~phase;
            if (!phase) hi_byte <= din_s2;
`ifdef CAM_CAPTURE_DECIM_EN
            if (phase) pix_par <= ~pix_par;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Pixel FIFO
    // ------------------------------------------------------------------
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

    // A full FIFO is never empty, so a concurrent rd_en always frees a slot.
    assign wr_ok = pix_keep && (!full || rd_en);
    assign drop  = pix_keep && full && !rd_en;
    assign rd_ok = rd_en && (!empty || wr_ok) && !start;

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr[FIFO_AW-1:0]] <= wr_word;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_data   <= 16'd0;
            overflow  <= 1'b0;
            pix_count <= 17'd0;
        end else if (start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            pix_count <= 17'd0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (pix_count != 17'h1FFFF) pix_count <= pix_count + 17'd1;
            end
            if (rd_ok) begin
                // Empty FIFO with a write this cycle: forward the new word.
                rd_data <= empty ? wr_word : mem[rd_ptr[FIFO_AW-1:0]];
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cam_capture.sv
module tb_cam_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        pclk, vsync, href;
    logic [7:0]  din;
    logic        take_picture, rd_en;
    logic [15:0] rd_data;
    logic        empty, busy, done, overflow;
    logic [16:0] pix_count;

    int errors = 0;
    int checks = 0;

    cam_capture #(.FIFO_AW(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .pclk         (pclk),
        .vsync        (vsync),
        .href         (href),
        .din          (din),
        .take_picture (take_picture),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .empty        (empty),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .pix_count    (pix_count)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [63:0] bytes;   // byte i at [63-8i -: 8]
        logic [3:0]  nbytes;
        logic [63:0] words;   // word i at [63-16i -: 16]
        logic [2:0]  nwords;
    } vec_t;

    vec_t vecs [5];

    // ---------------- driver tasks ----------------
    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic take_pic();
        take_picture = 1'b1;
        clks(1);
        take_picture = 1'b0;
        clks(1);
    endtask

    // One camera byte: data set while pclk low, rising edge after 4 clks.
    // With pop_at_edge, rd_en is timed to land on the same clk edge as the
    // FIFO write caused by this byte (two synchronizer stages later).
    task automatic cam_byte(input logic [7:0] b, input bit pop_at_edge);
        din  = b;
        pclk = 1'b0;
        clks(4);
        pclk = 1'b1;
        if (pop_at_edge) begin
            clks(2);
            rd_en = 1'b1;
            clks(1);
            rd_en = 1'b0;
            clks(1);
        end else begin
            clks(4);
        end
    endtask

    task automatic line_end();
        pclk = 1'b0;
        clks(4);
        href = 1'b0;
        clks(8);
    endtask

    task automatic frame_begin();
        vsync = 1'b0;
        clks(8);
    endtask

    task automatic frame_end();
        vsync = 1'b1;
        clks(10);
    endtask

    task automatic pop(output logic [15:0] w);
        rd_en = 1'b1;
        clks(1);
        rd_en = 1'b0;
        w = rd_data;
        clks(1);
    endtask

    task automatic pop_chk(input string name, input logic [15:0] exp);
        logic [15:0] w;
        pop(w);
        chk(name, {16'd0, w}, {16'd0, exp});
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0] w;
        rst = 1'b1; pclk = 1'b0; vsync = 1'b1; href = 1'b0; din = 8'd0;
        take_picture = 1'b0; rd_en = 1'b0;
        clks(3);
        rst = 1'b0;
        clks(2);

        chk("reset rd_data",   {16'd0, rd_data}, 32'h0);
        chk("reset empty",     {31'd0, empty},   32'h1);
        chk("reset busy",      {31'd0, busy},    32'h0);
        chk("reset done",      {31'd0, done},    32'h0);
        chk("reset overflow",  {31'd0, overflow},32'h0);
        chk("reset pix_count", {15'd0, pix_count}, 32'h0);

`ifdef CAM_CAPTURE_DECIM_EN
        // 4 lines x 4 pixels; pixel (L,P) = {L,P} , F0+P. Keep L,P in {0,2}.
        take_pic();
        chk("decim busy", {31'd0, busy}, 32'h1);
        frame_begin();
        for (int l = 0; l < 4; l++) begin
            href = 1'b1;
            for (int p = 0; p < 4; p++) begin
                cam_byte({l[3:0], p[3:0]}, 1'b0);
                cam_byte(8'hF0 | {4'd0, p[3:0]}, 1'b0);
            end
            line_end();
        end
        frame_end();
        chk("decim done",      {31'd0, done},      32'h1);
        chk("decim pix_count", {15'd0, pix_count}, 32'd4);
        chk("decim overflow",  {31'd0, overflow},  32'h0);
        pop_chk("decim w0", 16'h00F0);
        pop_chk("decim w1", 16'h02F2);
        pop_chk("decim w2", 16'h20F0);
        pop_chk("decim w3", 16'h22F2);
        chk("decim empty", {31'd0, empty}, 32'h1);
`else
        vecs[0] = '{64'h1122334455667788, 4'd8, 64'h1122334455667788, 3'd4};
        vecs[1] = '{64'hA1A2A3A4A5000000, 4'd5, 64'hA1A2A3A400000000, 3'd2};
        vecs[2] = '{64'hDEADBEEF00000000, 4'd4, 64'hDEADBEEF00000000, 3'd2};
        vecs[3] = '{64'h5500000000000000, 4'd1, 64'h0000000000000000, 3'd0};
        vecs[4] = '{64'h00FF000000000000, 4'd2, 64'h00FF000000000000, 3'd1};

        // Single-line frames from the table.
        for (int v = 0; v < 5; v++) begin
            take_pic();
            chk($sformatf("v%0d busy", v), {31'd0, busy}, 32'h1);
            chk($sformatf("v%0d done clr", v), {31'd0, done}, 32'h0);
            frame_begin();
            href = 1'b1;
            for (int i = 0; i < int'(vecs[v].nbytes); i++)
                cam_byte(vecs[v].bytes[63-8*i -: 8], 1'b0);
            line_end();
            frame_end();
            chk($sformatf("v%0d done", v), {31'd0, done}, 32'h1);
            chk($sformatf("v%0d busy off", v), {31'd0, busy}, 32'h0);
            chk($sformatf("v%0d pix_count", v), {15'd0, pix_count}, {29'd0, vecs[v].nwords});
            chk($sformatf("v%0d overflow", v), {31'd0, overflow}, 32'h0);
            for (int i = 0; i < int'(vecs[v].nwords); i++)
                pop_chk($sformatf("v%0d word%0d", v, i), vecs[v].words[63-16*i -: 16]);
            chk($sformatf("v%0d empty", v), {31'd0, empty}, 32'h1);
        end

        // Pop on empty leaves rd_data at the last popped word.
        pop(w);
        chk("pop empty rd_data", {16'd0, w}, 32'h00FF);

        // Overflow: 6 pixels into a 4-deep FIFO, no reads.
        take_pic();
        frame_begin();
        href = 1'b1;
        for (int i = 1; i <= 12; i++) cam_byte(i[7:0], 1'b0);
        line_end();
        frame_end();
        chk("ovf overflow",  {31'd0, overflow},  32'h1);
        chk("ovf pix_count", {15'd0, pix_count}, 32'd4);
        pop_chk("ovf w0", 16'h0102);
        pop_chk("ovf w1", 16'h0304);
        pop_chk("ovf w2", 16'h0506);
        pop_chk("ovf w3", 16'h0708);
        take_pic();
        chk("ovf clr overflow",  {31'd0, overflow},  32'h0);
        chk("ovf clr empty",     {31'd0, empty},     32'h1);
        chk("ovf clr pix_count", {15'd0, pix_count}, 32'h0);

        // Simultaneous write and pop while full (already armed).
        take_pic();  // ignored in ARM
        frame_begin();
        href = 1'b1;
        for (int i = 0; i < 9; i++) cam_byte(8'h10 + i[7:0], 1'b0);
        chk("sim full before", {31'd0, empty}, 32'h0);
        cam_byte(8'h19, 1'b1);
        line_end();
        frame_end();
        chk("sim rd_data",   {16'd0, rd_data},   32'h1011);
        chk("sim overflow",  {31'd0, overflow},  32'h0);
        chk("sim empty",     {31'd0, empty},     32'h0);
        chk("sim pix_count", {15'd0, pix_count}, 32'd5);
        pop_chk("sim w1", 16'h1213);
        pop_chk("sim w2", 16'h1415);
        pop_chk("sim w3", 16'h1617);
        pop_chk("sim w4", 16'h1819);
        chk("sim drained", {31'd0, empty}, 32'h1);

        // Reset mid-line after 3 bytes.
        take_pic();
        frame_begin();
        href = 1'b1;
        cam_byte(8'h31, 1'b0);
        cam_byte(8'h32, 1'b0);
        clks(4);
        chk("rstm pix_count pre", {15'd0, pix_count}, 32'd1);
        take_pic();  // ignored in CAPTURE
        chk("rstm ignore busy",  {31'd0, busy},  32'h1);
        chk("rstm ignore empty", {31'd0, empty}, 32'h0);
        cam_byte(8'h33, 1'b0);
        rst = 1'b1;
        clks(1);
        rst = 1'b0;
        clks(1);
        chk("rstm empty",     {31'd0, empty},     32'h1);
        chk("rstm busy",      {31'd0, busy},      32'h0);
        chk("rstm pix_count", {15'd0, pix_count}, 32'h0);
        chk("rstm rd_data",   {16'd0, rd_data},   32'h0);
        line_end();
        frame_end();
        frame_begin();
        href = 1'b1;
        for (int i = 0; i < 4; i++) cam_byte(8'h40 + i[7:0], 1'b0);
        line_end();
        frame_end();
        chk("rstm no write empty", {31'd0, empty},     32'h1);
        chk("rstm no write count", {15'd0, pix_count}, 32'h0);
        chk("rstm no write done",  {31'd0, done},      32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 SHALL have parameter FIFO_AW, default 4, pixel FIFO address width (depth 2**FIFO_AW words).
REQ-002 SHALL have one clock and one reset:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset, synchronous and active-high.
REQ-003 SHALL have the following camera and control ports:
- pclk  input  1  camera pixel clock, sampled as data.
- vsync  input  1  camera frame sync; high between frames.
- href  input  1  camera line valid.
- din  input  8  camera byte.
- take_picture  input  1  one-cycle start pulse.
- rd_en  input  1  pop one FIFO word.
- rd_data  output  16  popped pixel {first byte, second byte}.
- empty  output  1  FIFO holds no words.
- busy  output  1  state is ARM or CAPTURE.
- done  output  1  frame complete.
- overflow  output  1  sticky; a pixel was dropped.
- pix_count  output  17  pixels written this frame.

Function
REQ-004 SHALL pass pclk, vsync, href and din through the same two-stage register pipeline, so that they remain mutually aligned.
REQ-005 SHALL define a sample event as a synchronized pclk 0->1 transition; clk SHALL be at least 4x the pclk frequency.
REQ-006 SHALL implement the states IDLE, ARM, CAPTURE and DONE, with IDLE entered on reset.
REQ-007 In IDLE or DONE, take_picture SHALL:
- flush the FIFO;
- clear pix_count, overflow and done;
- enter ARM on the next cycle.
REQ-008 In ARM or CAPTURE, take_picture SHALL be ignored.
REQ-009 In ARM, a synchronized vsync 1->0 edge SHALL enter CAPTURE with the byte phase cleared.
REQ-010 In CAPTURE, on a sample event with href=1:
- phase 0 latches din as the high byte;
- phase 1 forms {high, din} and writes it to the FIFO;
- the phase toggles after each byte.
REQ-011 A synchronized href 1->0 edge SHALL reset the byte phase to 0; an odd trailing byte SHALL be discarded.
REQ-012 In CAPTURE, a synchronized vsync 0->1 edge SHALL enter DONE and set done=1; done SHALL stay 1 until the next take_picture.
REQ-013 A pixel write while the FIFO is full SHALL drop the pixel, set overflow, and leave pix_count unchanged.
REQ-014 pix_count SHALL increment on each successful write and saturate at 17'h1FFFF.
REQ-015 rd_en with empty=0 SHALL pop one word; rd_data SHALL be valid on the cycle after rd_en and hold until the next pop.
REQ-016 rd_en with empty=1 SHALL be ignored, leaving rd_data unchanged.
REQ-017 A simultaneous write and pop SHALL both succeed, including when the FIFO is full or when it is empty with a write pending.
REQ-018 The read and write pointers SHALL be FIFO_AW+1 bits wide and wrap modulo 2**(FIFO_AW+1); full is asserted when the MSBs differ and the remaining bits are equal.
REQ-019 busy SHALL be a combinational decode of state.

Reset
REQ-020 rst SHALL force the state to IDLE, clear both FIFO pointers, and clear the synchronizer pipeline, byte phase and parity bits.
REQ-021 Reset values of the outputs SHALL be:
- rd_data=0, empty=1, busy=0, done=0, overflow=0, pix_count=0.
REQ-022 rst asserted mid-frame SHALL abort the capture within one cycle and discard the partial pixel; the next frame SHALL require a new take_picture.

Configuration
REQ-023 Macro CAM_CAPTURE_DECIM_EN SHALL select 2:1 decimation.
REQ-024 With CAM_CAPTURE_DECIM_EN defined:
- a line parity bit is cleared on CAPTURE entry and toggles on each href 1->0 edge;
- a pixel parity bit is cleared on each href 1->0 edge and toggles per formed pixel;
- only pixels with both parities 0 are written and counted.
REQ-025 With CAM_CAPTURE_DECIM_EN undefined, every formed pixel SHALL be written and the parity logic SHALL be absent.

Verification
REQ-026 Single frame: take_picture, vsync 1->0, one href line of 8 bytes 0x11..0x88, vsync 0->1 -> words 0x1122, 0x3344, 0x5566, 0x7788; pix_count=4; done=1.
REQ-027 Odd line: 5 bytes 0xA1..0xA5 -> words 0xA1A2, 0xA3A4; 0xA5 discarded; pix_count=2.
REQ-028 Overflow (FIFO_AW=2): 6 pixels with no reads -> first 4 stored; overflow=1; pix_count=4; a following take_picture clears overflow and empty=1.
REQ-029 Simultaneous: FIFO full, rd_en coincides with a pixel write -> no drop; empty=0 and count stays 4.
REQ-030 Reset mid-line after 3 bytes -> empty=1, busy=0, pix_count=0; a new vsync edge without take_picture writes nothing.
REQ-031 Decimation (macro defined): 4 lines of 4 pixels -> 4 words, from lines 0 and 2, pixels 0 and 2; pix_count=4.
